// File: rtl/rr_src_sel4_pkg.sv
// Shared constants and types for the 4-channel round-robin source selector.
// The select codes are also consumed by the downstream 4:1 data selector.
package rr_src_sel4_pkg;

    localparam int NCH = 4;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam logic [1:0] CH2 = 2'b10;
    localparam logic [1:0] CH3 = 2'b11;

    // EMPTY: output register free; FULL: output register holds a word.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Round-robin successor of a channel index (3 wraps to 0).
    function automatic logic [1:0] next_chan(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_grant4.sv
// Combinational rotate/priority-encode: first requester at or after ptr wins.
// gnt_idx is only meaningful while gnt_vld is high.
module rr_grant4
    import rr_src_sel4_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     ptr,
    output logic           gnt_vld,
    output logic [1:0]     gnt_idx
);

    logic [1:0] w_cand;

    // Scan from the lowest-priority slot upward so the last hit is the winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        w_cand  = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_cand = ptr + k[1:0];
            if (req[w_cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_src_sel4.sv
// 4-channel round-robin source selector with a one-entry output register.
// Handshake: a transfer happens on any edge where valid and ready are both high.
module rr_src_sel4
    import rr_src_sel4_pkg::*;
#(
    parameter int DW = 2,
    parameter int CW = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [1:0]        out_chan,
    input  logic              out_ready,
    output logic [CW-1:0]     xfer_cnt,
    output state_t            o_dbg_state,
    output logic [1:0]        o_dbg_ptr
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ptr;
    logic [DW-1:0]   r_out_data;
    logic [1:0]      r_out_chan;
    logic [CW-1:0]   r_xfer_cnt;

    logic            w_gnt_vld;
    logic [1:0]      w_gnt_idx;
    logic            w_can_load;
    logic            w_xfer;
    logic [DW-1:0]   w_sel_data;

    rr_grant4 u_grant (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    // Loading is allowed when the register is empty or drains this same cycle.
    assign w_can_load = (r_state == ST_EMPTY) || out_ready;
    assign w_xfer     = w_gnt_vld && w_can_load && !rst;
    assign w_sel_data = in_data[int'(w_gnt_idx) * DW +: DW];

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_ptr      <= CH0;
            r_out_data <= '0;
            r_out_chan <= CH0;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_chan <= w_gnt_idx;
                r_ptr      <= next_chan(w_gnt_idx);
                r_xfer_cnt <= r_xfer_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid   = (r_state == ST_FULL);
    assign out_data    = r_out_data;
    assign out_chan    = r_out_chan;
    assign xfer_cnt    = r_xfer_cnt;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_src_sel4.sv
// Directed bench for rr_src_sel4: a default instance plus a CW=2 instance
// sharing the same stimulus to exercise the transfer-counter wrap.
module tb_rr_src_sel4;
    import rr_src_sel4_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic [3:0] in_ready, in_ready_c2;
    logic       out_valid, out_valid_c2;
    logic [1:0] out_data, out_data_c2;
    logic [1:0] out_chan, out_chan_c2;
    logic [7:0] xfer_cnt;
    logic [1:0] xfer_cnt_c2;
    state_t     dbg_state, dbg_state_c2;
    logic [1:0] dbg_ptr, dbg_ptr_c2;

    int n_vec;
    int n_miss;
    int n_xfer;
    logic [1:0] word_of [4];

    rr_src_sel4 #(.DW(2), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_chan(out_chan), .out_ready(out_ready), .xfer_cnt(xfer_cnt),
        .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr)
    );

    rr_src_sel4 #(.DW(2), .CW(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c2), .out_valid(out_valid_c2), .out_data(out_data_c2),
        .out_chan(out_chan_c2), .out_ready(out_ready), .xfer_cnt(xfer_cnt_c2),
        .o_dbg_state(dbg_state_c2), .o_dbg_ptr(dbg_ptr_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic [3:0] exp);
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] d,
                           input logic [1:0] c, input logic [1:0] p);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_data"},  32'(out_data),  32'(d));
        chk({tag, ".out_chan"},  32'(out_chan),  32'(c));
        chk({tag, ".ptr"},       32'(dbg_ptr),   32'(p));
        chk({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(n_xfer % 256));
        chk({tag, ".xfer_cnt_c2"}, 32'(xfer_cnt_c2), 32'(n_xfer % 4));
    endtask

    initial begin
        n_vec = 0; n_miss = 0; n_xfer = 0;
        rst = 1'b1; in_valid = 4'b0000; in_data = 8'h00; out_ready = 1'b0;

        // Reset, then single request on ch2.
        tick(); tick();
        chk_out("reset", 1'b0, 2'b00, 2'd0, 2'd0);
        chk("reset.state", 32'(dbg_state), 32'(ST_EMPTY));
        in_valid = 4'b0100; in_data = 8'b00_11_00_00; out_ready = 1'b1;
        chk_ready("reset.rst_gate", 4'b0000);
        rst = 1'b0;
        chk_ready("t1.grant", 4'b0100);
        tick(); n_xfer++;
        chk_out("t1", 1'b1, 2'b11, 2'd2, 2'd3);
        chk("t1.state", 32'(dbg_state), 32'(ST_FULL));

        // All channels requesting: ptr=3 gives ch3, then 0,1,2,3,0 back-to-back.
        word_of[0] = 2'd1; word_of[1] = 2'd2; word_of[2] = 2'd3; word_of[3] = 2'd0;
        in_data = 8'b00_11_10_01; in_valid = 4'b1111;
        chk_ready("t2.first", 4'b1000);
        tick(); n_xfer++;
        chk_out("t2.ch3", 1'b1, 2'd0, 2'd3, 2'd0);
        for (int g = 0; g < 5; g++) begin
            chk_ready($sformatf("t2.grant%0d", g), 4'b0001 << (g % 4));
            tick(); n_xfer++;
            chk_out($sformatf("t2.beat%0d", g), 1'b1, word_of[g % 4], 2'(g % 4), 2'((g + 1) % 4));
        end
        chk_ready("t3.pre", 4'b0010);
        tick(); n_xfer++;
        chk_out("t3.load_ch1", 1'b1, 2'd2, 2'd1, 2'd2);

        // Backpressure for three cycles with every channel requesting.
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk_ready($sformatf("t3.stall%0d", s), 4'b0000);
            tick();
            chk_out($sformatf("t3.hold%0d", s), 1'b1, 2'd2, 2'd1, 2'd2);
        end
        out_ready = 1'b1;
        chk_ready("t3.release", 4'b0100);
        tick(); n_xfer++;
        chk_out("t3.ch2", 1'b1, 2'd3, 2'd2, 2'd3);

        // Pointer wrap: ptr=3 with requests on 3 and 0.
        in_valid = 4'b1001;
        chk_ready("t4.wrap_a", 4'b1000);
        tick(); n_xfer++;
        chk_out("t4.ch3", 1'b1, 2'd0, 2'd3, 2'd0);
        chk_ready("t4.wrap_b", 4'b0001);
        tick(); n_xfer++;
        chk_out("t4.ch0", 1'b1, 2'd1, 2'd0, 2'd1);

        // Drain without refill, then an idle cycle: data/chan/ptr hold.
        in_valid = 4'b0000;
        chk_ready("drain.idle", 4'b0000);
        tick();
        chk_out("drain", 1'b0, 2'd1, 2'd0, 2'd1);
        chk("drain.state", 32'(dbg_state), 32'(ST_EMPTY));
        tick();
        chk_out("idle", 1'b0, 2'd1, 2'd0, 2'd1);

        // Reset in the middle of a stall discards the held word.
        in_valid = 4'b0010;
        chk_ready("t5.load", 4'b0010);
        tick(); n_xfer++;
        chk_out("t5.full", 1'b1, 2'd2, 2'd1, 2'd2);
        in_valid = 4'b1111; out_ready = 1'b0;
        tick();
        chk_out("t5.stall", 1'b1, 2'd2, 2'd1, 2'd2);
        rst = 1'b1; out_ready = 1'b1;
        chk_ready("t5.rst_gate", 4'b0000);
        tick(); n_xfer = 0;
        chk_out("t5.after_rst", 1'b0, 2'd0, 2'd0, 2'd0);
        rst = 1'b0; in_valid = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
